// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Byte stream from the UART receiver plus its error pulses.
// Revision : 1.0
// ============================================================================
interface uart_rx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       overflow;
    logic       framing_error;

    modport master (
        output tvalid,
        output tdata,
        output overflow,
        output framing_error,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  overflow,
        input  framing_error,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with mid-bit sampling and a one-entry
//            stream output register; overflow/framing errors as pulses.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int cycles_per_bit = 434
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  rx,
    uart_rx_if.master  o_axis
);

    localparam int              c_CW   = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(cycles_per_bit - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(cycles_per_bit / 2 - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } state_t;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    state_t          r_state;
    logic [c_CW-1:0] r_cycles;
    logic [2:0]      r_index;
    logic [7:0]      r_shift;
    logic            r_tvalid;
    logic [7:0]      r_tdata;
    logic            r_overflow;
    logic            r_framing_error;

    // rx is asynchronous; idle-high reset keeps a reset from looking like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cycles        <= '0;
            r_index         <= 3'd0;
            r_shift         <= 8'h00;
            r_tvalid        <= 1'b0;
            r_tdata         <= 8'h00;
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;

            // A delivery in ST_STOP below overrides this clear when both coincide
            if (r_tvalid && o_axis.tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state  <= ST_START;
                        r_cycles <= '0;
                    end
                end

                ST_START: begin
                    if (r_cycles == c_HALF) begin
                        if (!w_rx_s) begin
                            r_state  <= ST_DATA;
                            r_cycles <= '0;
                            r_index  <= 3'd0;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_cycles <= r_cycles + c_ONE;
                    end
                end

                ST_DATA: begin
                    if (r_cycles == c_LAST) begin
                        r_shift  <= {w_rx_s, r_shift[7:1]};
                        r_cycles <= '0;
                        if (r_index == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_index <= r_index + 3'd1;
                        end
                    end else begin
                        r_cycles <= r_cycles + c_ONE;
                    end
                end

                ST_STOP: begin
                    if (r_cycles == c_LAST) begin
                        if (w_rx_s) begin
                            if (!r_tvalid || o_axis.tready) begin
                                r_tdata  <= r_shift;
                                r_tvalid <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_framing_error <= 1'b1;
                            r_state         <= ST_BRK;
                        end
                    end else begin
                        r_cycles <= r_cycles + c_ONE;
                    end
                end

                ST_BRK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_axis.tvalid        = r_tvalid;
    assign o_axis.tdata         = r_tdata;
    assign o_axis.overflow      = r_overflow;
    assign o_axis.framing_error = r_framing_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Directed-plus-random bench for uart_rx; expectations come from frame-level
// reasoning (bytes sent, stop bits, consumer readiness), not from the FSM.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(.cycles_per_bit(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .o_axis (u_if)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         n_xfer = 0;
    int         n_ovf  = 0;
    int         n_fe   = 0;
    int         rise_cyc = -1;
    logic       prev_v = 1'b0;
    logic [7:0] xq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.tvalid && u_if.tready) begin
            n_xfer <= n_xfer + 1;
            xq.push_back(u_if.tdata);
        end
        if (u_if.overflow)       n_ovf <= n_ovf + 1;
        if (u_if.framing_error)  n_fe  <= n_fe + 1;
        if (u_if.tvalid && !prev_v) rise_cyc <= cyc;
        prev_v <= u_if.tvalid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0, lat, x0, o0, f0, nbad, gap;
        logic [7:0] b1, b;
        logic       bad;
        logic [7:0] exp_q[$];

        u_if.tready = 1'b0;
        rx          = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid",   {31'd0, u_if.tvalid},        32'd0);
        chk("rst_tdata",    {24'd0, u_if.tdata},         32'd0);
        chk("rst_overflow", {31'd0, u_if.overflow},      32'd0);
        chk("rst_framing",  {31'd0, u_if.framing_error}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(4);

        // Single byte and latency: stop sample lands at 2 + H + 9*CPB after the fall
        u_if.tready = 1'b1;
        xq.delete(); x0 = n_xfer;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        rx = 1'b1;
        wait_cycles(CPB);
        lat = rise_cyc - c0 - 1;
        chk("single_latency", {31'd0, (lat >= 2 + H + 9*CPB - 1) && (lat <= 2 + H + 9*CPB + 1)}, 32'd1);
        chk("single_count", n_xfer - x0, 32'd1);
        chk("single_data",  {24'd0, xq[0]}, 32'hA5);

        // Back-to-back frames into a stalled consumer
        u_if.tready = 1'b0;
        xq.delete(); x0 = n_xfer; o0 = n_ovf;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        wait_cycles(CPB);
        chk("stall_tvalid",   {31'd0, u_if.tvalid}, 32'd1);
        chk("stall_tdata",    {24'd0, u_if.tdata},  32'h00);
        chk("stall_overflow", n_ovf - o0, 32'd2);
        chk("stall_noxfer",   n_xfer - x0, 32'd0);
        u_if.tready = 1'b1;
        wait_cycles(4);
        u_if.tready = 1'b0;
        chk("stall_xfer_count", n_xfer - x0, 32'd1);
        chk("stall_xfer_data",  {24'd0, xq[0]}, 32'h00);
        chk("stall_drained",    {31'd0, u_if.tvalid}, 32'd0);

        // Accept the first byte on exactly the edge that delivers the second
        b1 = 8'($urandom);
        xq.delete(); x0 = n_xfer; o0 = n_ovf;
        fork
            begin
                send_frame(b1, 1'b1);
                send_frame(8'h55, 1'b1);
            end
            begin
                wait_cycles(10*CPB + 2 + H + 9*CPB - 1);
                u_if.tready = 1'b1;
                wait_cycles(1);
                u_if.tready = 1'b0;
            end
        join
        rx = 1'b1;
        chk("simul_tvalid",   {31'd0, u_if.tvalid}, 32'd1);
        chk("simul_tdata",    {24'd0, u_if.tdata},  32'h55);
        chk("simul_overflow", n_ovf - o0, 32'd0);
        chk("simul_count",    n_xfer - x0, 32'd1);
        chk("simul_first",    {24'd0, xq[0]}, {24'd0, b1});
        u_if.tready = 1'b1;
        wait_cycles(3);
        chk("simul_second",   {24'd0, xq[1]}, 32'h55);

        // Framing error followed by a long break, then a clean byte
        xq.delete(); x0 = n_xfer; o0 = n_ovf; f0 = n_fe;
        send_frame(8'h81, 1'b0);
        wait_cycles(40*CPB);
        rx = 1'b1;
        wait_cycles(CPB);
        send_frame(8'h42, 1'b1);
        rx = 1'b1;
        wait_cycles(CPB);
        chk("frame_fe_count", n_fe - f0, 32'd1);
        chk("frame_count",    n_xfer - x0, 32'd1);
        chk("frame_data",     {24'd0, xq[0]}, 32'h42);
        chk("frame_overflow", n_ovf - o0, 32'd0);

        // Short low glitch on an idle line
        x0 = n_xfer; o0 = n_ovf; f0 = n_fe;
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(3*CPB);
        chk("glitch_tvalid", {31'd0, u_if.tvalid}, 32'd0);
        chk("glitch_events", (n_xfer - x0) + (n_ovf - o0) + (n_fe - f0), 32'd0);

        // Reset during data bit 4 while a byte is still pending
        u_if.tready = 1'b0;
        send_frame(8'($urandom), 1'b1);
        rx = 1'b1;
        wait_cycles(CPB);
        chk("rstmid_pending", {31'd0, u_if.tvalid}, 32'd1);
        xq.delete(); x0 = n_xfer;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_cycles(5*CPB + H);
                rst_n = 1'b0;
                #1;
                chk("rstmid_tvalid",   {31'd0, u_if.tvalid},        32'd0);
                chk("rstmid_tdata",    {24'd0, u_if.tdata},         32'd0);
                chk("rstmid_overflow", {31'd0, u_if.overflow},      32'd0);
                chk("rstmid_framing",  {31'd0, u_if.framing_error}, 32'd0);
                wait_cycles(2);
                rst_n = 1'b1;
            end
        join
        rx = 1'b1;
        wait_cycles(CPB);
        chk("rstmid_no_f0", {31'd0, u_if.tvalid}, 32'd0);
        u_if.tready = 1'b1;
        send_frame(8'h0F, 1'b1);
        rx = 1'b1;
        wait_cycles(CPB);
        chk("rstmid_count", n_xfer - x0, 32'd1);
        chk("rstmid_data",  {24'd0, xq[0]}, 32'h0F);

        // Random bytes, random gaps, occasional bad stop bit
        xq.delete(); x0 = n_xfer; o0 = n_ovf; f0 = n_fe;
        nbad = 0;
        for (int k = 0; k < 12; k++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            rx = 1'b1;
            if (bad) begin
                nbad++;
            end else begin
                exp_q.push_back(b);
            end
            gap = bad ? CPB + int'($urandom_range(0, 8)) : int'($urandom_range(0, 8));
            if (gap > 0) wait_cycles(gap);
        end
        wait_cycles(2*CPB);
        chk("rand_count",    n_xfer - x0, exp_q.size());
        chk("rand_fe",       n_fe - f0, nbad);
        chk("rand_overflow", n_ovf - o0, 32'd0);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("rand_byte%0d", k), {24'd0, xq[k]}, {24'd0, exp_q[k]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
